// File: rtl/abro_pkg.sv
// Shared ABRO definitions: command order encodings, the stimulus driver's state
// set and the event pattern that each order produces.
package abro_pkg;

    localparam logic [1:0] ORD_AB  = 2'b00;
    localparam logic [1:0] ORD_BA  = 2'b01;
    localparam logic [1:0] ORD_SIM = 2'b10;
    localparam logic [1:0] ORD_AR  = 2'b11;

    localparam int unsigned ABRO_TIMEOUT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EMIT1,
        ST_GAP,
        ST_EMIT2,
        ST_WAIT_O,
        ST_REPORT
    } drv_state_e;

    // Event pattern packed as {A, B, R}
    function automatic logic [2:0] first_events(input logic [1:0] order);
        logic [2:0] ev;
        ev = 3'b000;
        unique case (order)
            ORD_AB:  ev = 3'b100;
            ORD_BA:  ev = 3'b010;
            ORD_SIM: ev = 3'b110;
            ORD_AR:  ev = 3'b100;
            default: ev = 3'b000;
        endcase
        return ev;
    endfunction

    function automatic logic [2:0] second_events(input logic [1:0] order);
        logic [2:0] ev;
        ev = 3'b000;
        unique case (order)
            ORD_AB:  ev = 3'b010;
            ORD_BA:  ev = 3'b100;
            ORD_AR:  ev = 3'b001;
            default: ev = 3'b000;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/abro_gap_counter.sv
// Loadable down-counter used to space ABRO events; reports when one cycle remains.
module abro_gap_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         is_one_c
);

    logic [W-1:0] count;

    // Decrement stops at zero so the counter can never wrap
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign is_one_c = (count == W'(1));

endmodule

// File: rtl/abro_stimulus_driver.sv
// Transaction initiator for the ABRO detector: turns one command into A/B/R
// pulses, watches O and reports pass/fail with the O latency.
module abro_stimulus_driver
    import abro_pkg::*;
#(
    parameter int unsigned DELAY_W = 8,
    parameter int unsigned TIMEOUT = ABRO_TIMEOUT,
    parameter int unsigned LAT_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_order,
    input  logic [DELAY_W-1:0] cmd_gap,
    output logic               A,
    output logic               B,
    output logic               R,
    input  logic               O,
    output logic               done,
    output logic               pass,
    output logic               early_o,
    output logic [LAT_W-1:0]   o_latency
);

    localparam logic [LAT_W-1:0] TIMER_MAX = LAT_W'(TIMEOUT - 1);

    drv_state_e          state;
    logic                ready_q;
    logic [1:0]          order_q;
    logic [DELAY_W-1:0]  gap_q;
    logic                expect_o;
    logic                early;
    logic [LAT_W-1:0]    timer;
    logic                cnt_is_one;

    // Ready is held low combinationally for as long as reset is asserted
    assign cmd_ready = ready_q & reset;

    abro_gap_counter #(
        .W(DELAY_W)
    ) u_gap (
        .clk      (clk),
        .reset    (reset),
        .load     (state == ST_EMIT1),
        .value    (gap_q),
        .dec      ((state == ST_GAP) && !cnt_is_one),
        .is_one_c (cnt_is_one)
    );

    // Event outputs are set on the edge that enters the emitting state,
    // so each pulse coincides with that state's single cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ready_q   <= 1'b1;
            order_q   <= ORD_AB;
            gap_q     <= '0;
            expect_o  <= 1'b0;
            early     <= 1'b0;
            timer     <= '0;
            A         <= 1'b0;
            B         <= 1'b0;
            R         <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            early_o   <= 1'b0;
            o_latency <= '0;
        end else begin
            A    <= 1'b0;
            B    <= 1'b0;
            R    <= 1'b0;
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        order_q   <= cmd_order;
                        gap_q     <= cmd_gap;
                        expect_o  <= (cmd_order != ORD_AR);
                        early     <= 1'b0;
                        ready_q   <= 1'b0;
                        {A, B, R} <= first_events(cmd_order);
                        state     <= ST_EMIT1;
                    end
                end
                ST_EMIT1: begin
                    early <= early | O;
                    if (order_q == ORD_SIM) begin
                        timer <= '0;
                        state <= ST_WAIT_O;
                    end else if (gap_q == '0) begin
                        {A, B, R} <= second_events(order_q);
                        state     <= ST_EMIT2;
                    end else begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    early <= early | O;
                    if (cnt_is_one) begin
                        {A, B, R} <= second_events(order_q);
                        state     <= ST_EMIT2;
                    end
                end
                ST_EMIT2: begin
                    early <= early | O;
                    timer <= '0;
                    state <= ST_WAIT_O;
                end
                ST_WAIT_O: begin
                    // O on the last timer cycle still counts as seen
                    if (O) begin
                        done      <= 1'b1;
                        pass      <= expect_o & ~early;
                        early_o   <= early;
                        o_latency <= timer;
                        state     <= ST_REPORT;
                    end else if (timer == TIMER_MAX) begin
                        done      <= 1'b1;
                        pass      <= ~expect_o & ~early;
                        early_o   <= early;
                        o_latency <= '1;
                        state     <= ST_REPORT;
                    end else begin
                        timer <= timer + LAT_W'(1);
                    end
                end
                ST_REPORT: begin
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_abro_stimulus_driver.sv
// Scoreboard bench for abro_stimulus_driver with a behavioural ABRO detector
// or a directly forced O line.
module tb_abro_stimulus_driver;
    import abro_pkg::*;

    localparam int unsigned DELAY_W = 8;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned LAT_W   = 5;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               cmd_valid = 1'b0;
    logic [1:0]         cmd_order = 2'b00;
    logic [DELAY_W-1:0] cmd_gap = '0;
    logic               cmd_ready;
    logic               A, B, R, O;
    logic               done, pass, early_o;
    logic [LAT_W-1:0]   o_latency;

    abro_stimulus_driver #(
        .DELAY_W(DELAY_W),
        .TIMEOUT(TIMEOUT),
        .LAT_W  (LAT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_order(cmd_order),
        .cmd_gap  (cmd_gap),
        .A        (A),
        .B        (B),
        .R        (R),
        .O        (O),
        .done     (done),
        .pass     (pass),
        .early_o  (early_o),
        .o_latency(o_latency)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Detector: O pulses the cycle after both A and B have been seen; R clears.
    logic ideal = 1'b0;
    logic o_force = 1'b0;
    logic det_o = 1'b0, seen_a = 1'b0, seen_b = 1'b0;
    always @(posedge clk) begin
        if (!reset || R || !ideal) begin
            seen_a <= 1'b0;
            seen_b <= 1'b0;
            det_o  <= 1'b0;
        end else if ((seen_a | A) && (seen_b | B)) begin
            seen_a <= 1'b0;
            seen_b <= 1'b0;
            det_o  <= 1'b1;
        end else begin
            seen_a <= seen_a | A;
            seen_b <= seen_b | B;
            det_o  <= 1'b0;
        end
    end
    assign O = ideal ? det_o : o_force;

    typedef struct {
        int         cyc;
        logic [2:0] abr;
    } ev_t;

    typedef struct {
        int             cyc;
        logic           pass;
        logic           early;
        logic [LAT_W-1:0] lat;
    } res_t;

    typedef struct {
        logic [1:0] order;
        int         gap;
        logic       ideal;
        int         force_off;
        logic [2:0] ev1;
        logic [2:0] ev2;
        int         ev2_off;
        int         done_off;
        logic       pass;
        logic       early;
        logic [4:0] lat;
    } vec_t;

    ev_t  ev_q[$];
    res_t res_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected events and results whenever the DUT shows them
    initial begin
        ev_t  e;
        res_t r;
        logic ready_chk;
        ready_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (ready_chk) begin
                check("cmd_ready_after_done", 32'(cmd_ready), 32'd1);
                ready_chk = 1'b0;
            end
            if ((A | B | R) !== 1'b0) begin
                if (ev_q.size() == 0) begin
                    check("event_unexpected", 32'({A, B, R}), 32'd0);
                end else begin
                    e = ev_q.pop_front();
                    check("event_cycle", 32'(cyc), 32'(e.cyc));
                    check("event_abr", 32'({A, B, R}), 32'(e.abr));
                end
            end
            if (done !== 1'b0) begin
                if (res_q.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    r = res_q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(r.cyc));
                    check("result_pass_early_lat", 32'({pass, early_o, o_latency}),
                          32'({r.pass, r.early, r.lat}));
                    check("cmd_ready_during_done", 32'(cmd_ready), 32'd0);
                    ready_chk = 1'b1;
                end
            end
        end
    end

    // Drives one command; expectations are queued before the accept edge.
    task automatic issue(input logic [1:0] order, input int gap, input logic [2:0] ev1,
                         input logic [2:0] ev2, input int ev2_off, output int tn);
        int budget;
        budget = 0;
        while (cmd_ready !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (cmd_ready !== 1'b1) check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        tn = cyc + 1;
        ev_q.push_back('{tn, ev1});
        if (ev2_off >= 0) ev_q.push_back('{tn + ev2_off, ev2});
        cmd_valid = 1'b1;
        cmd_order = order;
        cmd_gap   = DELAY_W'(gap);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drained();
        int budget;
        budget = 0;
        while ((res_q.size() != 0 || ev_q.size() != 0) && budget < 600) begin
            @(negedge clk);
            budget++;
        end
        check("scoreboard_drain", 32'(res_q.size() + ev_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int tn;
        ideal = v.ideal;
        o_force = 1'b0;
        res_q.push_back('{cyc + 1 + v.done_off, v.pass, v.early, v.lat});
        issue(v.order, v.gap, v.ev1, v.ev2, v.ev2_off, tn);
        if (v.force_off >= 0) begin
            while (cyc < tn + v.force_off) @(negedge clk);
            o_force = 1'b1;
            @(negedge clk);
            o_force = 1'b0;
        end
        wait_drained();
    endtask

    vec_t vecs[10];

    initial begin
        int tn;
        //            order   gap ideal force ev1     ev2     off2 done pass early lat
        vecs[0] = '{ORD_AB,   3, 1'b1, -1, 3'b100, 3'b010,   4,   6, 1'b1, 1'b0, 5'd0};
        vecs[1] = '{ORD_SIM,  7, 1'b1, -1, 3'b110, 3'b000,  -1,   2, 1'b1, 1'b0, 5'd0};
        vecs[2] = '{ORD_AR,   0, 1'b1, -1, 3'b100, 3'b001,   1,  18, 1'b1, 1'b0, 5'h1F};
        vecs[3] = '{ORD_BA,   2, 1'b0, -1, 3'b010, 3'b100,   3,  20, 1'b0, 1'b0, 5'h1F};
        vecs[4] = '{ORD_BA,   2, 1'b0,  1, 3'b010, 3'b100,   3,  20, 1'b0, 1'b1, 5'h1F};
        vecs[5] = '{ORD_AB,   0, 1'b0, 17, 3'b100, 3'b010,   1,  18, 1'b1, 1'b0, 5'd15};
        vecs[6] = '{ORD_AB,   0, 1'b1, -1, 3'b100, 3'b010,   1,   3, 1'b1, 1'b0, 5'd0};
        vecs[7] = '{ORD_AR,   1, 1'b0,  6, 3'b100, 3'b001,   2,   7, 1'b0, 1'b0, 5'd3};
        vecs[8] = '{ORD_BA, 255, 1'b1, -1, 3'b010, 3'b100, 256, 258, 1'b1, 1'b0, 5'd0};
        vecs[9] = '{ORD_SIM,  0, 1'b0,  0, 3'b110, 3'b000,  -1,  17, 1'b0, 1'b1, 5'h1F};

        // Reset values
        @(negedge clk);
        check("reset_abr", 32'({A, B, R}), 32'd0);
        check("reset_results", 32'({done, pass, early_o, o_latency}), 32'd0);
        check("reset_cmd_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset pulse while in GAP abandons the command without a done pulse
        ideal = 1'b1;
        issue(ORD_AB, 5, 3'b100, 3'b010, -1, tn);
        while (cyc < tn + 2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_abr", 32'({A, B, R}), 32'd0);
        check("midreset_cmd_ready_low", 32'(cmd_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("midreset_cmd_ready_high", 32'(cmd_ready), 32'd1);
        repeat (10) @(negedge clk);
        check("midreset_done_low", 32'(done), 32'd0);

        run_vec(vecs[0]);
        run_vec(vecs[7]);

        // Results persist after the done strobe
        repeat (5) @(negedge clk);
        check("result_hold", 32'({done, pass, early_o, o_latency}), 32'({1'b0, 1'b0, 1'b0, 5'd3}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
